// File: rtl/pipe_dbg_pkg.sv
// Shared constants for the debug-controlled pipeline stage: modes, FSM states,
// end-of-program marker and debug-word field offsets.
package pipe_dbg_pkg;

  localparam logic [1:0] MODE_FROZEN = 2'b00;
  localparam logic [1:0] MODE_CONT   = 2'b01;
  localparam logic [1:0] MODE_STEP   = 2'b11;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StRun       = 3'd1,
    StStepWait  = 3'd2,
    StStepFire  = 3'd3,
    StHalt      = 3'd4
  } state_e;

  localparam logic [31:0] EOF_WORD = 32'h69656F66;

  localparam int unsigned DBG_VALID  = 0;
  localparam int unsigned DBG_EOF    = 1;
  localparam int unsigned DBG_HALTED = 2;
  localparam int unsigned DBG_STATE  = 3;
  localparam int unsigned DBG_PC     = 8;

  // 2'b10 is reserved and parks the stage like frozen.
  function automatic state_e mode_to_state(input logic [1:0] mode);
    case (mode)
      MODE_FROZEN: return StIdle;
      MODE_CONT:   return StRun;
      MODE_STEP:   return StStepWait;
      default:     return StIdle;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_latch.sv
// Reusable pipeline register with stall/flush, debug run control (freeze,
// run, single-step, halt on end-of-program) and cycle/bubble statistics.
module pipe_stage_latch #(
  parameter int unsigned            NB_INSTRUCT = 32,
  parameter int unsigned            NB_PC       = 32,
  parameter int unsigned            NB_CNT      = 16,
  parameter logic [NB_INSTRUCT-1:0] EOF_WORD    = NB_INSTRUCT'(pipe_dbg_pkg::EOF_WORD),
  parameter int unsigned            NB_DBG      = 8 + NB_PC + NB_INSTRUCT
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [1:0]             i_mode,
  input  logic                   i_step,
  input  logic                   i_resume,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_valid,
  input  logic [NB_INSTRUCT-1:0] i_instruction,
  input  logic [NB_PC-1:0]       i_pc,
  output logic                   o_valid,
  output logic [NB_INSTRUCT-1:0] o_instruction,
  output logic [NB_PC-1:0]       o_pc,
  output logic                   o_eof,
  output logic                   o_halted,
  output logic                   o_advance,
  output logic [NB_CNT-1:0]      o_cycle_cnt,
  output logic [NB_CNT-1:0]      o_bubble_cnt,
  output logic [NB_DBG-1:0]      o_dbg_data
);

  import pipe_dbg_pkg::*;

  state_e                 state_q;
  logic                   step_prev_q;
  logic                   valid_q;
  logic                   eof_q;
  logic [NB_INSTRUCT-1:0] instr_q;
  logic [NB_PC-1:0]       pc_q;

  logic                   halted;
  logic                   step_edge;
  logic                   advance;
  logic                   load_valid;
  logic                   load_eof;
  logic [NB_INSTRUCT-1:0] load_instr;
  logic [NB_PC-1:0]       load_pc;

  // Flush only matters when the stage actually moves; otherwise it is dropped.
  always_comb begin
    halted     = (state_q == StHalt);
    step_edge  = i_step && !step_prev_q;
    advance    = ((state_q == StRun) || (state_q == StStepFire)) && !i_stall && !halted;
    load_valid = i_flush ? 1'b0 : i_valid;
    load_instr = i_flush ? '0 : i_instruction;
    load_pc    = i_flush ? '0 : i_pc;
    load_eof   = !i_flush && i_valid && (i_instruction == EOF_WORD);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      step_prev_q <= 1'b0;
      valid_q     <= 1'b0;
      eof_q       <= 1'b0;
      instr_q     <= '0;
      pc_q        <= '0;
    end else begin
      step_prev_q <= i_step;

      if (advance) begin
        valid_q <= load_valid;
        instr_q <= load_instr;
        pc_q    <= load_pc;
        eof_q   <= load_eof;
      end

      if (advance && load_eof) begin
        state_q <= StHalt;
      end else begin
        case (state_q)
          StHalt: begin
            if (i_resume) begin
              state_q <= StIdle;
              eof_q   <= 1'b0;
            end
          end
          StStepWait: state_q <= step_edge ? StStepFire : mode_to_state(i_mode);
          default:    state_q <= mode_to_state(i_mode);
        endcase
      end
    end
  end

  sat_counter #(
    .WIDTH (NB_CNT)
  ) u_cycle_cnt (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .en    (advance),
    .count (o_cycle_cnt)
  );

  sat_counter #(
    .WIDTH (NB_CNT)
  ) u_bubble_cnt (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .en    (advance && !load_valid),
    .count (o_bubble_cnt)
  );

  always_comb begin
    o_dbg_data                              = '0;
    o_dbg_data[DBG_VALID]                   = valid_q;
    o_dbg_data[DBG_EOF]                     = eof_q;
    o_dbg_data[DBG_HALTED]                  = halted;
    o_dbg_data[DBG_STATE +: 3]              = state_q;
    o_dbg_data[DBG_PC +: NB_PC]             = pc_q;
    o_dbg_data[DBG_PC + NB_PC +: NB_INSTRUCT] = instr_q;
  end

  assign o_valid       = valid_q;
  assign o_instruction = instr_q;
  assign o_pc          = pc_q;
  assign o_eof         = eof_q;
  assign o_halted      = halted;
  assign o_advance     = advance;

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Directed bench for pipe_stage_latch: a 16-bit-counter instance and a 4-bit
// counter instance driven by the same stimulus.
module tb_pipe_stage_latch;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic        step;
  logic        resume;
  logic        stall;
  logic        flush;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;

  logic        v16, eof16, halt16, adv16;
  logic [31:0] ins16, pc16;
  logic [15:0] cyc16, bub16;
  logic [71:0] dbg16;

  logic        v4, eof4, halt4, adv4;
  logic [31:0] ins4, pc4;
  logic [3:0]  cyc4, bub4;
  logic [71:0] dbg4;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] EOFW = 32'h69656F66;

  pipe_stage_latch dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_mode        (mode),
    .i_step        (step),
    .i_resume      (resume),
    .i_stall       (stall),
    .i_flush       (flush),
    .i_valid       (valid),
    .i_instruction (instr),
    .i_pc          (pc),
    .o_valid       (v16),
    .o_instruction (ins16),
    .o_pc          (pc16),
    .o_eof         (eof16),
    .o_halted      (halt16),
    .o_advance     (adv16),
    .o_cycle_cnt   (cyc16),
    .o_bubble_cnt  (bub16),
    .o_dbg_data    (dbg16)
  );

  pipe_stage_latch #(
    .NB_CNT (4)
  ) dut4 (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_mode        (mode),
    .i_step        (step),
    .i_resume      (resume),
    .i_stall       (stall),
    .i_flush       (flush),
    .i_valid       (valid),
    .i_instruction (instr),
    .i_pc          (pc),
    .o_valid       (v4),
    .o_instruction (ins4),
    .o_pc          (pc4),
    .o_eof         (eof4),
    .o_halted      (halt4),
    .o_advance     (adv4),
    .o_cycle_cnt   (cyc4),
    .o_bubble_cnt  (bub4),
    .o_dbg_data    (dbg4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    mode = 2'b00; step = 0; resume = 0; stall = 0; flush = 0;
    valid = 0; instr = '0; pc = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    mode = 2'b00; step = 0; resume = 0; stall = 0; flush = 0;
    valid = 0; instr = '0; pc = '0;
    #12;
    check_eq("rst_valid", {71'd0, v16}, 72'd0);
    check_eq("rst_dbg", dbg16, 72'd0);
    check_eq("rst_cycle", {56'd0, cyc16}, 72'd0);
    rst_n = 1'b1;

    // 1: continuous run, one-cycle latency
    tick();
    mode = 2'b01;
    tick();
    valid = 1; instr = 32'h11; pc = 32'd4;
    tick();
    check_eq("t1_ins_a", {40'd0, ins16}, 72'h11);
    check_eq("t1_pc_a", {40'd0, pc16}, 72'd4);
    instr = 32'h22; pc = 32'd8;
    tick();
    check_eq("t1_ins_b", {40'd0, ins16}, 72'h22);
    instr = 32'h33; pc = 32'd12;
    tick();
    check_eq("t1_dbg_c", dbg16, {32'h33, 32'hc, 8'h09});
    check_eq("t1_cycle", {56'd0, cyc16}, 72'd3);
    check_eq("t1_bubble", {56'd0, bub16}, 72'd0);

    // 2: stall holds, flush ignored while stalled, then flush bubble
    instr = 32'h44; pc = 32'd16;
    stall = 1;
    tick();
    check_eq("t2_hold_ins", {40'd0, ins16}, 72'h33);
    flush = 1;
    tick();
    check_eq("t2_hold_valid", {71'd0, v16}, 72'd1);
    check_eq("t2_hold_cycle", {56'd0, cyc16}, 72'd3);
    stall = 0;
    #1;
    check_eq("t2_adv_comb", {71'd0, adv16}, 72'd1);
    tick();
    check_eq("t2_flush_valid", {71'd0, v16}, 72'd0);
    check_eq("t2_flush_ins", {40'd0, ins16}, 72'd0);
    check_eq("t2_bubble", {56'd0, bub16}, 72'd1);
    check_eq("t2_cycle", {56'd0, cyc16}, 72'd4);
    flush = 0; stall = 1; mode = 2'b00;
    tick();
    stall = 0;

    // 3: single-step, held-high step fires once
    do_reset();
    mode = 2'b11;
    tick();
    check_eq("t3_wait_state", {69'd0, dbg16[5:3]}, 72'd2);
    valid = 1; instr = 32'hAA; pc = 32'h100; step = 1;
    tick();
    check_eq("t3_fire_state", {69'd0, dbg16[5:3]}, 72'd3);
    check_eq("t3_pre_load", {40'd0, ins16}, 72'd0);
    tick();
    check_eq("t3_load_a", {40'd0, ins16}, 72'hAA);
    instr = 32'hBB; pc = 32'h104;
    tick(3);
    check_eq("t3_held_ins", {40'd0, ins16}, 72'hAA);
    check_eq("t3_held_cycle", {56'd0, cyc16}, 72'd1);
    step = 0;
    tick();
    step = 1;
    tick();
    tick();
    check_eq("t3_load_b", {40'd0, ins16}, 72'hBB);
    check_eq("t3_load_b_pc", {40'd0, pc16}, 72'h104);
    step = 0;
    tick(2);
    check_eq("t3_cycle", {56'd0, cyc16}, 72'd2);

    // 4: end-of-program halt and resume
    do_reset();
    mode = 2'b01;
    tick();
    valid = 1; instr = EOFW; pc = 32'h40;
    tick();
    check_eq("t4_eof", {71'd0, eof16}, 72'd1);
    check_eq("t4_halted", {71'd0, halt16}, 72'd1);
    check_eq("t4_dbg", dbg16, {EOFW, 32'h40, 8'h27});
    instr = 32'h55; pc = 32'h44; step = 1;
    tick(2);
    check_eq("t4_ignore_pc", {40'd0, pc16}, 72'h40);
    check_eq("t4_ignore_cycle", {56'd0, cyc16}, 72'd1);
    mode = 2'b00; resume = 1; step = 0;
    tick();
    resume = 0;
    check_eq("t4_res_halted", {71'd0, halt16}, 72'd0);
    check_eq("t4_res_eof", {71'd0, eof16}, 72'd0);
    check_eq("t4_res_state", {69'd0, dbg16[5:3]}, 72'd0);

    // 5: counter saturation
    do_reset();
    mode = 2'b01;
    tick();
    tick(20);
    check_eq("t5_cyc4", {68'd0, cyc4}, 72'd15);
    check_eq("t5_bub4", {68'd0, bub4}, 72'd15);
    check_eq("t5_cyc16", {56'd0, cyc16}, 72'd20);

    // 6: asynchronous reset during STEP_FIRE
    valid = 1; instr = 32'h77; pc = 32'h80; mode = 2'b11;
    tick();
    step = 1;
    tick();
    check_eq("t6_fire_state", {69'd0, dbg16[5:3]}, 72'd3);
    check_eq("t6_pre_pc", {40'd0, pc16}, 72'h80);
    check_eq("t6_pre_cycle", {56'd0, cyc16}, 72'd21);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_pc", {40'd0, pc16}, 72'd0);
    check_eq("t6_rst_ins", {40'd0, ins16}, 72'd0);
    check_eq("t6_rst_cycle", {56'd0, cyc16}, 72'd0);
    check_eq("t6_rst_adv", {71'd0, adv16}, 72'd0);
    check_eq("t6_rst_dbg", dbg16, 72'd0);
    #1;
    rst_n = 1'b1;
    step = 0; mode = 2'b00;
    tick();
    check_eq("t6_post_state", {69'd0, dbg16[5:3]}, 72'd0);
    check_eq("t6_post_ins", {40'd0, ins16}, 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
